// File: rtl/omp_x_arb.sv
// Round-robin arbiter sharing one single-port block RAM between two OMP compute stages.
// Optional post-reset zero-fill sweep is compiled in with OMP_X_ARB_CLEAR_EN.
module omp_x_arb #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int MEM_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic              ram_ce0,
    output logic [DWIDTH-1:0] ram_d0,
    output logic              ram_we0,
    input  logic [DWIDTH-1:0] ram_q0,
    output logic              busy
);

    logic              last_q, last_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DWIDTH-1:0] rdata1_q, rdata1_d;
    logic              clearing;
    logic [AWIDTH-1:0] clr_addr;

`ifdef OMP_X_ARB_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam logic [AWIDTH:0] CLR_LAST = (AWIDTH+1)'(MEM_SIZE - 1);

    state_t          state_q, state_d;
    logic [AWIDTH:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clearing = rst_n && (state_q == S_CLEAR);
    assign clr_addr = clr_cnt_q[AWIDTH-1:0];
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = clearing;

    // Arbitration and RAM port steering; ram_q0 never feeds this block.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        ram_ce0   = 1'b0;
        ram_we0   = 1'b0;
        ram_addr0 = m0_addr;
        ram_d0    = m0_wdata;
        if (clearing) begin
            ram_ce0   = 1'b1;
            ram_we0   = 1'b1;
            ram_addr0 = clr_addr;
            ram_d0    = '0;
        end else if (rst_n) begin
            if (m0_req && (!m1_req || last_q)) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
            if (m1_gnt) begin
                ram_addr0 = m1_addr;
                ram_d0    = m1_wdata;
            end
            ram_ce0 = m0_gnt | m1_gnt;
            ram_we0 = (m0_gnt & m0_we) | (m1_gnt & m1_we);
        end
    end

    // Read data is taken straight from the RAM in the valid cycle, then held.
    assign m0_rvalid = rvalid0_q & rst_n;
    assign m1_rvalid = rvalid1_q & rst_n;
    assign m0_rdata  = m0_rvalid ? ram_q0 : rdata0_q;
    assign m1_rdata  = m1_rvalid ? ram_q0 : rdata1_q;

    always_comb begin
        last_d    = last_q;
        rvalid0_d = m0_gnt & ~m0_we;
        rvalid1_d = m1_gnt & ~m1_we;
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
        if (m0_gnt) begin
            last_d = 1'b0;
        end else if (m1_gnt) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_omp_x_arb.sv
// Scoreboard bench for omp_x_arb: RAM model, high-level arbitration model, decoupled read monitor.
// Exercises the OMP_X_ARB_CLEAR_EN sweep when that macro is defined.
module tb_omp_x_arb;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MS = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr0;
    logic          ram_ce0, ram_we0, busy;
    logic [DW-1:0] ram_d0;
    logic [DW-1:0] ram_q0 = '0;

    omp_x_arb #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr0(ram_addr0), .ram_ce0(ram_ce0), .ram_d0(ram_d0), .ram_we0(ram_we0),
        .ram_q0(ram_q0), .busy(busy)
    );

    always #5 clk = ~clk;

    // Physical RAM: 1-cycle registered read, write-through.
    logic [DW-1:0] ram [MS];
    always @(posedge clk) begin
        if (ram_ce0) begin
            if (ram_we0) begin
                ram[ram_addr0] <= ram_d0;
                ram_q0         <= ram_d0;
            end else begin
                ram_q0 <= ram[ram_addr0];
            end
        end
    end

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp0[$];
    exp_t          exp1[$];
    logic [DW-1:0] ref_mem [MS];
    int            model_last = 1;
    logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
    int            cur_cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    always @(posedge clk) cur_cyc <= cur_cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    // Monitor: each rvalid pops the oldest outstanding read of that requester.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (m0_rvalid) begin
                if (exp0.size() == 0) begin
                    chk("m0_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp0.pop_front();
                    chk("m0_rlat", DW'(cur_cyc), DW'(e.cyc + 1));
                    chk("m0_rdata", m0_rdata, e.data);
                    last_rd0 = e.data;
                    $display("rd m0 addr=%h data=%h", e.addr, m0_rdata);
                end
            end else begin
                chk("m0_rdata_hold", m0_rdata, last_rd0);
                while (exp0.size() > 0 && exp0[0].cyc + 1 < cur_cyc) begin
                    chk("m0_rvalid_missing", 32'd0, 32'd1);
                    void'(exp0.pop_front());
                end
            end
            if (m1_rvalid) begin
                if (exp1.size() == 0) begin
                    chk("m1_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp1.pop_front();
                    chk("m1_rlat", DW'(cur_cyc), DW'(e.cyc + 1));
                    chk("m1_rdata", m1_rdata, e.data);
                    last_rd1 = e.data;
                    $display("rd m1 addr=%h data=%h", e.addr, m1_rdata);
                end
            end else begin
                chk("m1_rdata_hold", m1_rdata, last_rd1);
                while (exp1.size() > 0 && exp1[0].cyc + 1 < cur_cyc) begin
                    chk("m1_rvalid_missing", 32'd0, 32'd1);
                    void'(exp1.pop_front());
                end
            end
        end
    end

    // One bus cycle: drive, check the grant against the fairness rule, update the model.
    task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output logic g0, output logic g1);
        int   win;
        exp_t e;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
        if (r0 && r1) win = 1 - model_last;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        else          win = -1;
        chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, win == 0});
        chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, win == 1});
        chk("ram_ce0", {31'd0, ram_ce0}, {31'd0, win >= 0});
        chk("busy_run", {31'd0, busy}, 32'd0);
        if (win >= 0) begin
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            we = (win == 0) ? w0 : w1;
            a  = (win == 0) ? a0 : a1;
            d  = (win == 0) ? d0 : d1;
            chk("ram_addr0", DW'(ram_addr0), DW'(a));
            chk("ram_we0", {31'd0, ram_we0}, {31'd0, we});
            if (we) begin
                chk("ram_d0", ram_d0, d);
                ref_mem[a] = d;
            end else begin
                e.cyc = cur_cyc; e.data = ref_mem[a]; e.addr = a;
                if (win == 0) exp0.push_back(e);
                else          exp1.push_back(e);
            end
            model_last = win;
        end
        g0 = (win == 0);
        g1 = (win == 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        exp0.delete(); exp1.delete();
        last_rd0 = '0; last_rd1 = '0;
        model_last = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_ce", {31'd0, ram_ce0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef OMP_X_ARB_CLEAR_EN
        m0_req = 1; m0_we = 0; m0_addr = '0;
        for (int i = 0; i < MS; i++) begin
            @(negedge clk);
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_m0_gnt", {31'd0, m0_gnt}, 32'd0);
            chk("clr_we", {30'd0, ram_ce0, ram_we0}, 32'd3);
            chk("clr_addr", DW'(ram_addr0), DW'(i));
            chk("clr_d", ram_d0, 32'd0);
            @(posedge clk); #1;
        end
        m0_req = 0;
        for (int i = 0; i < MS; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin
        logic g0, g1;
        logic          p0_req, p0_we, p1_req, p1_we;
        logic [AW-1:0] p0_a, p1_a;
        logic [DW-1:0] p0_d, p1_d;
        for (int i = 0; i < MS; i++) begin
            ram[i]     = $urandom | 32'h1;
            ref_mem[i] = ram[i];
        end
        @(posedge clk); #1;
        do_reset();

`ifdef OMP_X_ARB_CLEAR_EN
        cycle(1, 0, 8'h00, 0, 0, 0, 0, 0, g0, g1);
        cycle(1, 0, 8'h7F, 0, 0, 0, 0, 0, g0, g1);
        cycle(1, 0, 8'hFF, 0, 0, 0, 0, 0, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
`endif
        // single requester: write then read back
        cycle(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1);
        chk("t1_first_gnt", {31'd0, g0}, 32'd1);
        cycle(1, 0, 8'h10, 0, 0, 0, 0, 0, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("t1_rdata", last_rd0, 32'hDEADBEEF);

        // conflict fairness after a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, g0, g1);
            chk("t2_alt", {31'd0, g0}, {31'd0, (i % 2) == 0});
        end
        // idle gap, then conflict goes to the one not granted last (m0)
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        cycle(1, 0, 8'h03, 0, 1, 0, 8'h04, 0, g0, g1);
        chk("t3_after_idle", {31'd0, g0}, 32'd1);
        cycle(0, 0, 0, 0, 1, 0, 8'h04, 0, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // reset while m1's read is in flight
        cycle(0, 0, 0, 0, 1, 0, 8'h05, 0, g0, g1);
        chk("t4_m1_gnt", {31'd0, g1}, 32'd1);
        do_reset();
        cycle(1, 0, 8'h06, 0, 1, 0, 8'h07, 0, g0, g1);
        chk("t4_post_rst_m0", {31'd0, g0}, 32'd1);
        cycle(0, 0, 0, 0, 1, 0, 8'h07, 0, g0, g1);

        // randomized traffic; a losing requester holds its request
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
        g0 = 1; g1 = 1;
        for (int i = 0; i < 400; i++) begin
            if (!p0_req || g0) begin
                p0_req = ($urandom_range(0, 99) < 70);
                p0_we  = $urandom_range(0, 1);
                p0_a   = AW'($urandom_range(0, 15));
                p0_d   = $urandom;
            end
            if (!p1_req || g1) begin
                p1_req = ($urandom_range(0, 99) < 70);
                p1_we  = $urandom_range(0, 1);
                p1_a   = AW'($urandom_range(0, 15));
                p1_d   = $urandom;
            end
            cycle(p0_req, p0_we, p0_a, p0_d, p1_req, p1_we, p1_a, p1_d, g0, g1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("end_q0_empty", exp0.size(), 32'd0);
        chk("end_q1_empty", exp1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/omp_x_arb.md
Name: omp_x_arb

Overview:
- Two-requester arbiter and sequencer for one single-port block RAM (32-bit x 256 words, 1-cycle registered read, write-through on write).
- Sits between two OMP compute stages (m0, m1) and the RAM.
- Shares the RAM port round-robin, returns read data to the winning requester, and optionally zero-fills the RAM after reset.

Parameters:
- DWIDTH, 32, data width; must match RAM.
- AWIDTH, 8, address width; must match RAM.
- MEM_SIZE, 256, words in RAM; used only by the clear sweep.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- m0_req  in  1  requester 0 wants the port this cycle
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AWIDTH  address
- m0_wdata  in  DWIDTH  write data
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid  out  1  read data valid (registered)
- m0_rdata  out  DWIDTH  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for requester 1
- ram_addr0  out  AWIDTH  RAM address
- ram_ce0  out  1  RAM enable
- ram_d0  out  DWIDTH  RAM write data
- ram_we0  out  1  RAM write enable
- ram_q0  in  DWIDTH  RAM read data, valid 1 cycle after ce0 with we0=0
- busy  out  1  clear sweep in progress

Behaviour:
- States: CLEAR (only with the optional feature) and RUN. Reset enters CLEAR if the feature is compiled in, otherwise RUN.
- Reset values (rst_n=0 at a clock edge):
  - m*_gnt=0, m*_rvalid=0, m*_rdata=0
  - ram_ce0=0, ram_we0=0
  - rr pointer last=1, so m0 wins the first conflict
  - busy=0
  - gnt and ram_ce0 are forced 0 combinationally while rst_n=0.
- RUN arbitration (combinational):
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last.
  - Neither high: no grant, ram_ce0=0.
- Granted requester drives ram_addr0, ram_d0 and ram_we0=m*_we, with ram_ce0=1. The non-granted requester must hold its req and fields until granted.
- last updates to the granted index on every grant cycle; otherwise it holds.
- Read latency: grant at cycle N with we=0 -> that requester's rvalid=1 at N+1, rdata=ram_q0 sampled the same cycle. rvalid is a 1-cycle pulse.
- Writes produce no rvalid.
- Back-to-back: a requester granted on consecutive cycles gets consecutive rvalid pulses. Each rdata register holds its last value until the next read completes.
- Same address, write at N then read at N+1 returns the new data.
- Reset mid-operation: a pending rvalid is cancelled (not issued at the next cycle) and the arbiter returns to the initial state.
- No combinational path from ram_q0 to any gnt.

Optional Feature:
- Macro: OMP_X_ARB_CLEAR_EN
- Defined:
  - After reset deassertion, CLEAR writes 0 to addresses 0..MEM_SIZE-1, one per cycle: ram_ce0=1, ram_we0=1, ram_d0=0, ram_addr0 = counter.
  - busy=1 and all gnt=0 for exactly MEM_SIZE cycles.
  - Requests are ignored (stalled) during the sweep.
  - After the last address, go to RUN and busy=0 on the next cycle.
  - Counter width is AWIDTH+1 so MEM_SIZE=2^AWIDTH terminates with no wrap.
  - Reset during CLEAR restarts the sweep from address 0.
- Undefined: no CLEAR state, no counter, busy tied 0, RUN immediately after reset.

Test Plan:
- Reset then single requester: m0 write addr 0x10 data 0xDEADBEEF, next cycle m0 read 0x10 -> m0_gnt=1 both cycles; m0_rvalid=1 one cycle later with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Conflict fairness: m0_req=m1_req=1 continuously, reads of 0x01 and 0x02 -> grants alternate m0, m1, m0, m1 (first to m0); each rvalid arrives exactly 1 cycle after its grant with the correct word.
- Idle cycle: both req=0 for 3 cycles -> ram_ce0=0; last unchanged. The next conflict goes to the requester not granted most recently.
- Reset mid-read: m1 granted a read at cycle N, rst_n=0 sampled at N+1 -> m1_rvalid=0 at N+1; after release the first conflict goes to m0.
- With OMP_X_ARB_CLEAR_EN: preload RAM nonzero, then reset and hold m0_req=1 -> busy=1 and m0_gnt=0 for 256 cycles; afterwards reads of 0x00, 0x7F and 0xFF return 0.
- Without OMP_X_ARB_CLEAR_EN: m0_req=1 on the first cycle after reset -> m0_gnt=1 immediately; busy=0 throughout.
